// File: rtl/dlx_pkg.sv
// DLX instruction word layout shared by the fetch queue and its field decoder.
package dlx_pkg;

    localparam int unsigned INSTR_W   = 32;
    localparam int unsigned OPCODE_W  = 6;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned REG_W     = 5;
    localparam int unsigned RS_LSB    = 21;
    localparam int unsigned RT_LSB    = 16;
    localparam int unsigned RD_LSB    = 11;
    localparam int unsigned SHAMT_W   = 5;
    localparam int unsigned SHAMT_LSB = 6;
    localparam int unsigned FUNCT_W   = 6;
    localparam int unsigned FUNCT_LSB = 0;
    localparam int unsigned IMM_W     = 16;
    localparam int unsigned JADDR_W   = 26;

    localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    function automatic logic [INSTR_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(INSTR_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/instruction_queue_if.sv
// Fetch-side push handshake and decode-side pop handshake of the instruction queue.
interface instruction_queue_if;
    import dlx_pkg::*;

    logic [INSTR_W-1:0] MemData;
    logic               MemValid;
    logic               MemReady;
    logic               IRTake;
    logic               IRValid;
    logic [INSTR_W-1:0] Instruction;

    modport master (
        output MemData, MemValid, IRTake,
        input  MemReady, IRValid, Instruction
    );

    modport slave (
        input  MemData, MemValid, IRTake,
        output MemReady, IRValid, Instruction
    );

endinterface

// File: rtl/ir_field_decode.sv
// Splits a DLX instruction word into its R/I/J-format fields; purely combinational.
module ir_field_decode
    import dlx_pkg::*;
(
    input  logic [INSTR_W-1:0]  Word,
    output logic [OPCODE_W-1:0] OpCode,
    output logic [REG_W-1:0]    RS,
    output logic [REG_W-1:0]    RT,
    output logic [REG_W-1:0]    RD,
    output logic [SHAMT_W-1:0]  SHAMT,
    output logic [FUNCT_W-1:0]  FUNCT,
    output logic [IMM_W-1:0]    Immediate,
    output logic [JADDR_W-1:0]  JumpAddr,
    output logic [INSTR_W-1:0]  ImmSext
);

    assign OpCode    = Word[OPCODE_LSB +: OPCODE_W];
    assign RS        = Word[RS_LSB +: REG_W];
    assign RT        = Word[RT_LSB +: REG_W];
    assign RD        = Word[RD_LSB +: REG_W];
    assign SHAMT     = Word[SHAMT_LSB +: SHAMT_W];
    assign FUNCT     = Word[FUNCT_LSB +: FUNCT_W];
    assign Immediate = Word[IMM_W-1:0];
    assign JumpAddr  = Word[JADDR_W-1:0];
    assign ImmSext   = sext_imm(Word[IMM_W-1:0]);

endmodule

// File: rtl/instruction_queue.sv
// Flop-based instruction prefetch FIFO with flush and decoded head-word fields.
module instruction_queue
    import dlx_pkg::*;
#(
    parameter int unsigned        DEPTH     = 4,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
)(
    input  logic                         Clock,
    input  logic                         Reset_n,
    instruction_queue_if.slave           q,
    input  logic                         Flush,
    output logic [OPCODE_W-1:0]          OpCode,
    output logic [REG_W-1:0]             RS,
    output logic [REG_W-1:0]             RT,
    output logic [REG_W-1:0]             RD,
    output logic [SHAMT_W-1:0]           SHAMT,
    output logic [FUNCT_W-1:0]           FUNCT,
    output logic [IMM_W-1:0]             Immediate,
    output logic [JADDR_W-1:0]           JumpAddr,
    output logic [INSTR_W-1:0]           ImmSext,
    output logic [$clog2(DEPTH+1)-1:0]   Count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [INSTR_W-1:0] head_word;
    logic               push;
    logic               pop;

    // Ready comes only from the registered count, so a same-cycle pop never frees a slot.
    assign q.MemReady = (Count != CNT_W'(DEPTH));
    assign q.IRValid  = (Count != '0);
    assign push       = q.MemValid && q.MemReady && !Flush;
    assign pop        = q.IRTake && q.IRValid && !Flush;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            head  <= '0;
            tail  <= '0;
            Count <= '0;
        end else if (Flush) begin
            head  <= '0;
            tail  <= '0;
            Count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   Count <= Count + CNT_W'(1);
                2'b01:   Count <= Count - CNT_W'(1);
                default: Count <= Count;
            endcase
        end
    end

    // Storage is deliberately unreset; validity is tracked by Count alone.
    always_ff @(posedge Clock) begin
        if (push && Reset_n) mem[tail] <= q.MemData;
    end

    assign head_word     = q.IRValid ? mem[head] : NOP_INSTR;
    assign q.Instruction = head_word;

    ir_field_decode u_decode (
        .Word      (head_word),
        .OpCode    (OpCode),
        .RS        (RS),
        .RT        (RT),
        .RD        (RD),
        .SHAMT     (SHAMT),
        .FUNCT     (FUNCT),
        .Immediate (Immediate),
        .JumpAddr  (JumpAddr),
        .ImmSext   (ImmSext)
    );

endmodule

// File: tb/tb_instruction_queue.sv
// Directed self-checking bench for instruction_queue (DEPTH=4, non-zero NOP word).
module tb_instruction_queue;
    import dlx_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_8020;

    logic        Clock;
    logic        Reset_n;
    logic        Flush;
    logic [5:0]  OpCode;
    logic [4:0]  RS, RT, RD, SHAMT;
    logic [5:0]  FUNCT;
    logic [15:0] Immediate;
    logic [25:0] JumpAddr;
    logic [31:0] ImmSext;
    logic [2:0]  Count;

    int vectors;
    int miscompares;

    instruction_queue_if bus ();

    instruction_queue #(
        .DEPTH     (4),
        .NOP_INSTR (NOP)
    ) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .q         (bus.slave),
        .Flush     (Flush),
        .OpCode    (OpCode),
        .RS        (RS),
        .RT        (RT),
        .RD        (RD),
        .SHAMT     (SHAMT),
        .FUNCT     (FUNCT),
        .Immediate (Immediate),
        .JumpAddr  (JumpAddr),
        .ImmSext   (ImmSext),
        .Count     (Count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        logic [31:0] words [5];
        vectors     = 0;
        miscompares = 0;
        Reset_n      = 1'b0;
        Flush        = 1'b0;
        bus.MemData  = '0;
        bus.MemValid = 1'b0;
        bus.IRTake   = 1'b0;
        #12;

        check("rst_count",   32'(Count),         32'd0);
        check("rst_irvalid", 32'(bus.IRValid),   32'd0);
        check("rst_ready",   32'(bus.MemReady),  32'd1);
        check("rst_instr",   bus.Instruction,    NOP);
        check("rst_sext",    ImmSext,            32'hFFFF_8020);
        check("rst_rd",      32'(RD),            32'd16);
        check("rst_funct",   32'(FUNCT),         32'h20);
        Reset_n = 1'b1;

        // first push of a load word, visible one cycle later
        bus.MemData = 32'h8C22_FFFC; bus.MemValid = 1'b1;
        tick();
        bus.MemValid = 1'b0;
        check("p1_irvalid", 32'(bus.IRValid), 32'd1);
        check("p1_opcode",  32'(OpCode),      32'h23);
        check("p1_rs",      32'(RS),          32'd1);
        check("p1_rt",      32'(RT),          32'd2);
        check("p1_imm",     32'(Immediate),   32'hFFFC);
        check("p1_sext",    ImmSext,          32'hFFFF_FFFC);
        check("p1_jaddr",   32'(JumpAddr),    32'h022_FFFC);
        check("p1_count",   32'(Count),       32'd1);

        bus.IRTake = 1'b1;
        tick();
        check("pop1_count", 32'(Count),        32'd0);
        check("pop1_instr", bus.Instruction,   NOP);
        tick();
        bus.IRTake = 1'b0;
        check("empty_pop_count", 32'(Count),       32'd0);
        check("empty_pop_valid", 32'(bus.IRValid), 32'd0);

        // fill past capacity; fifth word must be dropped
        words[0] = 32'h1000_0001; words[1] = 32'h2000_0002; words[2] = 32'h3000_0003;
        words[3] = 32'h4000_0004; words[4] = 32'h5000_0005;
        for (int i = 0; i < 5; i++) begin
            bus.MemData = words[i]; bus.MemValid = 1'b1;
            tick();
            check("fill_count", 32'(Count),        (i < 3) ? 32'(i + 1) : 32'd4);
            check("fill_ready", 32'(bus.MemReady), (i < 3) ? 32'd1 : 32'd0);
        end
        bus.MemValid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("drain_word", bus.Instruction, words[i]);
            bus.IRTake = 1'b1;
            tick();
        end
        bus.IRTake = 1'b0;
        check("drain_valid", 32'(bus.IRValid), 32'd0);
        check("drain_instr", bus.Instruction,  NOP);

        // full queue: push and pop together -> pop only, push lands next cycle
        for (int i = 0; i < 4; i++) begin
            bus.MemData = 32'hA000_0000 + 32'(i); bus.MemValid = 1'b1;
            tick();
        end
        bus.MemData = 32'hA000_0004; bus.IRTake = 1'b1;
        tick();
        bus.IRTake = 1'b0;
        check("full_pp_count", 32'(Count),      32'd3);
        check("full_pp_head",  bus.Instruction, 32'hA000_0001);
        tick();
        bus.MemValid = 1'b0;
        check("full_retry_count", 32'(Count), 32'd4);
        for (int i = 1; i < 5; i++) begin
            check("full_drain", bus.Instruction, 32'hA000_0000 + 32'(i));
            bus.IRTake = 1'b1;
            tick();
        end
        bus.IRTake = 1'b0;

        // flush beats push and pop in the same cycle
        for (int i = 0; i < 3; i++) begin
            bus.MemData = 32'hB000_0000 + 32'(i); bus.MemValid = 1'b1;
            tick();
        end
        check("pre_flush_count", 32'(Count), 32'd3);
        Flush = 1'b1; bus.MemData = 32'hBADB_AD00; bus.IRTake = 1'b1;
        tick();
        Flush = 1'b0; bus.IRTake = 1'b0;
        check("flush_count", 32'(Count),       32'd0);
        check("flush_valid", 32'(bus.IRValid), 32'd0);
        check("flush_instr", bus.Instruction,  NOP);
        bus.MemData = 32'hC000_0000;
        tick();
        bus.MemValid = 1'b0;
        check("post_flush_head",  bus.Instruction, 32'hC000_0000);
        check("post_flush_count", 32'(Count),      32'd1);
        bus.IRTake = 1'b1;
        tick();
        bus.IRTake = 1'b0;

        // streaming push+pop across several pointer wraps
        for (int i = 0; i < 2; i++) begin
            bus.MemData = 32'hD000_0000 + 32'(i); bus.MemValid = 1'b1;
            tick();
        end
        for (int i = 0; i < 12; i++) begin
            check("stream_head", bus.Instruction, 32'hD000_0000 + 32'(i));
            bus.MemData = 32'hD000_0000 + 32'(i + 2); bus.IRTake = 1'b1;
            tick();
            check("stream_count", 32'(Count), 32'd2);
        end
        bus.MemValid = 1'b0; bus.IRTake = 1'b0;
        check("stream_tail_head", bus.Instruction, 32'hD000_000C);

        // asynchronous reset pulse between edges
        #2 Reset_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(bus.IRValid),  32'd0);
        check("async_rst_count", 32'(Count),        32'd0);
        check("async_rst_ready", 32'(bus.MemReady), 32'd1);
        check("async_rst_instr", bus.Instruction,   NOP);
        #1 Reset_n = 1'b1;
        bus.MemData = 32'hE000_0000; bus.MemValid = 1'b1;
        tick();
        bus.MemValid = 1'b0;
        check("post_rst_head",  bus.Instruction, 32'hE000_0000);
        check("post_rst_count", 32'(Count),      32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_queue.md
INSTRUCTION_QUEUE -- requirements
Module: instruction_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of instruction entries; legal values are powers of two from 2 to 16.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, SHALL be the instruction word presented whenever the queue is empty.
REQ-003 Clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 MemData  input  32  SHALL carry the fetched instruction word.
REQ-006 MemValid  input  1  SHALL request a push of MemData.
REQ-007 MemReady  output  1  SHALL be high when the queue is not full.
REQ-008 IRTake  input  1  SHALL request a pop of the head entry.
REQ-009 IRValid  output  1  SHALL be high when the queue holds at least one entry.
REQ-010 Flush  input  1  SHALL discard all entries (branch/jump redirect).
REQ-011 Instruction  output  32  SHALL be the head entry, or NOP_INSTR when empty.
REQ-012 OpCode 6, RS 5, RT 5, RD 5, SHAMT 5, FUNCT 6, Immediate 16, JumpAddr 26 (all outputs) SHALL be Instruction[31:26], [25:21], [20:16], [15:11], [10:6], [5:0], [15:0], [25:0] respectively.
REQ-013 ImmSext  output  32  SHALL be Immediate sign-extended from bit 15.
REQ-014 Count  output  $clog2(DEPTH+1)  SHALL be the number of valid entries.

Function
REQ-015 A push SHALL occur when MemValid && MemReady && !Flush; MemData written at the tail, tail pointer advances modulo DEPTH.
REQ-016 A pop SHALL occur when IRTake && IRValid && !Flush; head pointer advances modulo DEPTH.
REQ-017 MemReady SHALL depend only on registered Count (Count != DEPTH); no combinational path from IRTake to MemReady.
REQ-018 Push-to-visible latency SHALL be one cycle: a word pushed into an empty queue appears on Instruction and IRValid the following cycle.
REQ-019 Simultaneous push and pop on a non-empty, non-full queue SHALL leave Count unchanged and advance both pointers.
REQ-020 Pop request while empty SHALL be ignored; Count stays 0, pointers unchanged.
REQ-021 Push request while full SHALL be ignored; stored data unchanged; upstream holds MemData.
REQ-022 Flush SHALL take priority over push and pop in the same cycle: next cycle Count = 0, pointers = 0, IRValid = 0, Instruction = NOP_INSTR; the coincident MemData is discarded.
REQ-023 Pointers SHALL be $clog2(DEPTH) bits and wrap naturally; full/empty determined from Count, not pointer comparison.
REQ-024 All decoded field outputs SHALL be purely combinational from Instruction (zero additional latency).
REQ-025 Storage array contents SHALL not be reset; only pointers and Count are.

Reset
REQ-026 Reset_n low SHALL asynchronously force head = 0, tail = 0, Count = 0, giving IRValid = 0, MemReady = 1, Instruction = NOP_INSTR, ImmSext and all fields = fields of NOP_INSTR.
REQ-027 Reset_n assertion mid-operation SHALL discard all entries with no partial push committed; deassertion is synchronised externally and the first push may occur on the first rising edge after release.

Structure
REQ-028 Package dlx_pkg SHALL hold instruction field bit positions/widths, the NOP_INSTR default constant, and the opcode width constants.
REQ-029 One sub-module, ir_field_decode, SHALL split a 32-bit word into OpCode/RS/RT/RD/SHAMT/FUNCT/Immediate/JumpAddr/ImmSext; instruction_queue instantiates it on the head word.
REQ-030 Storage SHALL be a flop array of DEPTH x 32 with registered pointers; no memory macro.

Verification
REQ-031 Reset then push 32'h8C22_FFFC -> next cycle IRValid=1, OpCode=6'h23, RS=1, RT=2, Immediate=16'hFFFC, ImmSext=32'hFFFF_FFFC, Count=1.
REQ-032 DEPTH=4: push 5 words with IRTake=0 -> MemReady=0 after 4th, 5th ignored; then pop 4 -> words in order, then IRValid=0, Instruction=NOP_INSTR.
REQ-033 Full queue, MemValid=1 and IRTake=1 same cycle -> pop only (push blocked by REQ-017), Count=3; next cycle push accepted, Count=4.
REQ-034 Count=3 with Flush=1, MemValid=1, IRTake=1 -> next cycle Count=0, IRValid=0, flushed-cycle word never appears.
REQ-035 Continuous push+pop for 3*DEPTH cycles -> in-order output across pointer wrap, Count constant.
REQ-036 Reset_n pulsed low asynchronously between edges with Count=2 -> IRValid and Count drop immediately, MemReady=1.
